// File: rtl/rf_commit_scheduler_pkg.sv
// Shared types for the register-file commit scheduler: flush sequencing states,
// commit entry layout and default field widths.
package rf_sched_pkg;

  localparam int ROB_ID_W = 5;
  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [REG_ID_W-1:0] reg_id;
    logic [XLEN-1:0]     value;
  } commit_entry_t;

endpackage

// File: rtl/rf_commit_scheduler_if.sv
// ROB-facing commit/flush handshake plus the register-file commit and clear outputs.
interface rf_commit_scheduler_if #(
  parameter int ROB_ID_W = rf_sched_pkg::ROB_ID_W,
  parameter int REG_ID_W = rf_sched_pkg::REG_ID_W,
  parameter int XLEN     = rf_sched_pkg::XLEN
);
  logic                c0_valid;
  logic [ROB_ID_W-1:0] c0_rob_id;
  logic [REG_ID_W-1:0] c0_reg_id;
  logic [XLEN-1:0]     c0_value;
  logic                c1_valid;
  logic [ROB_ID_W-1:0] c1_rob_id;
  logic [REG_ID_W-1:0] c1_reg_id;
  logic [XLEN-1:0]     c1_value;
  logic                commit_ready;
  logic                clear_req;
  logic                clear_busy;
  logic                rf_commit_ready;
  logic [ROB_ID_W-1:0] rf_commit_rob_id;
  logic [REG_ID_W-1:0] rf_commit_reg_id;
  logic [XLEN-1:0]     rf_commit_value;
  logic                rf_clear;

  modport master (
    output c0_valid, c0_rob_id, c0_reg_id, c0_value,
    output c1_valid, c1_rob_id, c1_reg_id, c1_value,
    output clear_req,
    input  commit_ready, clear_busy,
    input  rf_commit_ready, rf_commit_rob_id, rf_commit_reg_id, rf_commit_value, rf_clear
  );

  modport slave (
    input  c0_valid, c0_rob_id, c0_reg_id, c0_value,
    input  c1_valid, c1_rob_id, c1_reg_id, c1_value,
    input  clear_req,
    output commit_ready, clear_busy,
    output rf_commit_ready, rf_commit_rob_id, rf_commit_reg_id, rf_commit_value, rf_clear
  );
endinterface

// File: rtl/rf_commit_scheduler_fifo.sv
// In-order commit FIFO with two write ports (slot 0 lands before slot 1) and one read port.
module commit_fifo
  import rf_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = commit_entry_t
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     en,
  input  logic                     push0,
  input  entry_t                   din0,
  input  logic                     push1,
  input  entry_t                   din1,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_1;

  // Slot 1 follows slot 0 when both push; otherwise it takes the current write slot.
  assign wr_ptr_1 = push0 ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (en) begin
      if (push0) mem[wr_ptr]   <= din0;
      if (push1) mem[wr_ptr_1] <= din1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/rf_commit_scheduler.sv
// Dual-commit to single-write-port scheduler with FIFO bypass and a drain-then-clear flush sequencer.
module rf_commit_scheduler
  import rf_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ROB_ID_W = rf_sched_pkg::ROB_ID_W,
  parameter int REG_ID_W = rf_sched_pkg::REG_ID_W,
  parameter int XLEN     = rf_sched_pkg::XLEN
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  input logic                  rdy_in,
  rf_commit_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [REG_ID_W-1:0] reg_id;
    logic [XLEN-1:0]     value;
  } entry_t;

  sched_state_t     state;
  logic [CNT_W-1:0] count;
  entry_t           slot0, slot1, head, entry_p1;
  logic             vld_p1, busy_q, rf_clear_q;
  logic             commit_ok, keep0, keep1, fifo_empty, pop;
  logic             bypass0, bypass1, push0, push1;

  // Conservative: looks only at the registered count, never at a same-cycle pop.
  assign commit_ok  = rdy_in && (state == ST_IDLE) && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));

  assign slot0      = '{rob_id: bus.c0_rob_id, reg_id: bus.c0_reg_id, value: bus.c0_value};
  assign slot1      = '{rob_id: bus.c1_rob_id, reg_id: bus.c1_reg_id, value: bus.c1_value};

  // Writes to x0 are accepted from the ROB but never reach the register file.
  assign keep0      = bus.c0_valid && commit_ok && (bus.c0_reg_id != '0);
  assign keep1      = bus.c1_valid && commit_ok && (bus.c1_reg_id != '0);

  assign fifo_empty = (count == '0);
  assign pop        = rdy_in && !fifo_empty;
  assign bypass0    = keep0 && fifo_empty;
  assign bypass1    = keep1 && fifo_empty && !keep0;
  assign push0      = keep0 && !fifo_empty;
  assign push1      = keep1 && !bypass1;

  commit_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (rdy_in),
    .push0    (push0),
    .din0     (slot0),
    .push1    (push1),
    .din1     (slot1),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // ---- stage p1: register-file commit port and flush sequencer ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      vld_p1     <= 1'b0;
      entry_p1   <= '0;
      busy_q     <= 1'b0;
      rf_clear_q <= 1'b0;
    end else if (rdy_in) begin
      if (pop) begin
        vld_p1   <= 1'b1;
        entry_p1 <= head;
      end else if (bypass0) begin
        vld_p1   <= 1'b1;
        entry_p1 <= slot0;
      end else if (bypass1) begin
        vld_p1   <= 1'b1;
        entry_p1 <= slot1;
      end else begin
        vld_p1   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          rf_clear_q <= 1'b0;
          if (bus.clear_req) begin
            state  <= ST_DRAIN;
            busy_q <= 1'b1;
          end
        end
        // Nothing can be accepted here, so an empty FIFO means the last write already issued.
        ST_DRAIN: begin
          if (fifo_empty) begin
            state      <= ST_CLEAR;
            rf_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state      <= ST_IDLE;
          rf_clear_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          rf_clear_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.commit_ready     = commit_ok;
  assign bus.clear_busy       = busy_q;
  assign bus.rf_clear         = rf_clear_q;
  assign bus.rf_commit_ready  = vld_p1;
  assign bus.rf_commit_rob_id = entry_p1.rob_id;
  assign bus.rf_commit_reg_id = entry_p1.reg_id;
  assign bus.rf_commit_value  = entry_p1.value;

endmodule

// File: tb/tb_rf_commit_scheduler.sv
// Bench for rf_commit_scheduler: directed vector table, hand-written flush/freeze/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_rf_commit_scheduler;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic rdy;
  int   nvec;
  int   nerr;

  rf_commit_scheduler_if bus ();

  rf_commit_scheduler #(.DEPTH(DEPTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c0v;
    logic [4:0]  c0rob;
    logic [4:0]  c0reg;
    logic [31:0] c0val;
    logic        c1v;
    logic [4:0]  c1rob;
    logic [4:0]  c1reg;
    logic [31:0] c1val;
    logic        e1v;
    logic [4:0]  e1rob;
    logic [4:0]  e1reg;
    logic [31:0] e1val;
    logic        e2v;
    logic [4:0]  e2rob;
    logic [4:0]  e2reg;
    logic [31:0] e2val;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rob;
    logic [4:0]  rg;
    logic [31:0] val;
  } ent_t;

  vec_t vecs [6];
  ent_t pend [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slots(input logic v0, input logic [4:0] r0, input logic [4:0] g0,
                           input logic [31:0] d0, input logic v1, input logic [4:0] r1,
                           input logic [4:0] g1, input logic [31:0] d1);
    bus.c0_valid  = v0;
    bus.c0_rob_id = r0;
    bus.c0_reg_id = g0;
    bus.c0_value  = d0;
    bus.c1_valid  = v1;
    bus.c1_rob_id = r1;
    bus.c1_reg_id = g1;
    bus.c1_value  = d1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [4:0] rob,
                         input logic clr, input logic busy);
    chk({nm, "_vld"}, bus.rf_commit_ready, v);
    if (v) chk({nm, "_rob"}, bus.rf_commit_rob_id, rob);
    chk({nm, "_clr"}, bus.rf_clear, clr);
    chk({nm, "_busy"}, bus.clear_busy, busy);
  endtask

  task automatic fill_three(input logic [4:0] base);
    set_slots(1'b1, base, 5'd1, 32'h100, 1'b1, base + 5'd1, 5'd2, 32'h101);
    #1 chk("fill_cr0", bus.commit_ready, 1'b1);
    tick();
    chk_out("fill_e1", 1'b1, base, 1'b0, 1'b0);
    chk("fill_e1_val", bus.rf_commit_value, 32'h100);
    set_slots(1'b1, base + 5'd2, 5'd3, 32'h102, 1'b1, base + 5'd3, 5'd4, 32'h103);
    #1 chk("fill_cr1", bus.commit_ready, 1'b1);
    tick();
    chk_out("fill_e2", 1'b1, base + 5'd1, 1'b0, 1'b0);
    set_slots(1'b1, base + 5'd4, 5'd5, 32'h104, 1'b1, base + 5'd5, 5'd6, 32'h105);
    #1 chk("fill_cr2", bus.commit_ready, 1'b1);
    tick();
    chk_out("fill_e3", 1'b1, base + 5'd2, 1'b0, 1'b0);
    set_slots(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    #1 chk("fill_cr_full", bus.commit_ready, 1'b0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.clear_req = 1'b0;
    set_slots(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    vecs[0] = '{1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0,
                1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[1] = '{1'b1, 5'd4, 5'd1, 32'h11, 1'b1, 5'd5, 5'd2, 32'h22,
                1'b1, 5'd4, 5'd1, 32'h11, 1'b1, 5'd5, 5'd2, 32'h22};
    vecs[2] = '{1'b1, 5'd6, 5'd0, 32'h66, 1'b1, 5'd7, 5'd9, 32'h99,
                1'b1, 5'd7, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[3] = '{1'b0, 5'd2, 5'd2, 32'h2, 1'b1, 5'd8, 5'd3, 32'h88,
                1'b1, 5'd8, 5'd3, 32'h88, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[4] = '{1'b1, 5'd9, 5'd0, 32'h9, 1'b1, 5'd10, 5'd0, 32'hA,
                1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[5] = '{1'b1, 5'd11, 5'd4, 32'hB, 1'b1, 5'd12, 5'd0, 32'hC,
                1'b1, 5'd11, 5'd4, 32'hB, 1'b0, 5'd0, 5'd0, 32'h0};

    // Reset state
    tick();
    tick();
    chk_out("rst", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rst_rob", bus.rf_commit_rob_id, 5'd0);
    chk("rst_val", bus.rf_commit_value, 32'd0);
    chk("rst_cr", bus.commit_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Table vectors, each from an idle empty block
    for (int i = 0; i < 6; i++) begin
      set_slots(vecs[i].c0v, vecs[i].c0rob, vecs[i].c0reg, vecs[i].c0val,
                vecs[i].c1v, vecs[i].c1rob, vecs[i].c1reg, vecs[i].c1val);
      tick();
      set_slots(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
      chk($sformatf("v%0d_e1_vld", i), bus.rf_commit_ready, vecs[i].e1v);
      if (vecs[i].e1v) begin
        chk($sformatf("v%0d_e1_rob", i), bus.rf_commit_rob_id, vecs[i].e1rob);
        chk($sformatf("v%0d_e1_reg", i), bus.rf_commit_reg_id, vecs[i].e1reg);
        chk($sformatf("v%0d_e1_val", i), bus.rf_commit_value, vecs[i].e1val);
      end
      tick();
      chk($sformatf("v%0d_e2_vld", i), bus.rf_commit_ready, vecs[i].e2v);
      if (vecs[i].e2v) begin
        chk($sformatf("v%0d_e2_rob", i), bus.rf_commit_rob_id, vecs[i].e2rob);
        chk($sformatf("v%0d_e2_reg", i), bus.rf_commit_reg_id, vecs[i].e2reg);
        chk($sformatf("v%0d_e2_val", i), bus.rf_commit_value, vecs[i].e2val);
      end
      tick();
    end

    // Backpressure then flush with three entries queued
    fill_three(5'd10);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk_out("fl1", 1'b1, 5'd13, 1'b0, 1'b1);
    tick();
    chk_out("fl2", 1'b1, 5'd14, 1'b0, 1'b1);
    tick();
    chk_out("fl3", 1'b1, 5'd15, 1'b0, 1'b1);
    tick();
    chk_out("fl_clear", 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    chk_out("fl_idle", 1'b0, 5'd0, 1'b0, 1'b0);

    // Flush with an empty block: rf_clear two cycles after clear_req
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk_out("fe_drain", 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    chk_out("fe_clear", 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    chk_out("fe_idle", 1'b0, 5'd0, 1'b0, 1'b0);

    // Freeze mid-drain, then reset during drain
    fill_three(5'd20);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk_out("fz_d", 1'b1, 5'd23, 1'b0, 1'b1);
    rdy = 1'b0;
    #1 chk("fz_cr", bus.commit_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("fz_hold", 1'b1, 5'd23, 1'b0, 1'b1);
    end
    rdy = 1'b1;
    tick();
    chk_out("fz_resume", 1'b1, 5'd24, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("rd_rst", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rd_rst_rob", bus.rf_commit_rob_id, 5'd0);
    chk("rd_rst_reg", bus.rf_commit_reg_id, 5'd0);
    chk("rd_rst_val", bus.rf_commit_value, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("rd_after", 1'b0, 5'd0, 1'b0, 1'b0);
    end
    chk("rd_cr", bus.commit_ready, 1'b1);

    // Randomized traffic against the reference model (block is idle and empty here)
    begin
      int   mphase;
      int   old_sz;
      logic m_cr, m_vld;
      ent_t m_out;
      logic c0v, c1v, creq;
      ent_t s0, s1;
      mphase = 0;
      m_vld  = 1'b0;
      m_out  = '0;
      pend.delete();
      for (int i = 0; i < 3000; i++) begin
        rdy  = ($urandom_range(0, 9) != 0);
        c0v  = ($urandom_range(0, 9) < 6);
        c1v  = ($urandom_range(0, 9) < 6);
        creq = ($urandom_range(0, 29) == 0);
        s0.rob = 5'($urandom);
        s0.rg  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        s0.val = $urandom;
        s1.rob = 5'($urandom);
        s1.rg  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        s1.val = $urandom;
        set_slots(c0v, s0.rob, s0.rg, s0.val, c1v, s1.rob, s1.rg, s1.val);
        bus.clear_req = creq;
        m_cr = rdy && (mphase == 0) && ((DEPTH - pend.size()) >= 2);
        #1 chk("rnd_cr", bus.commit_ready, m_cr);
        @(posedge clk);
        if (rdy) begin
          old_sz = pend.size();
          if (m_cr && c0v && s0.rg != 5'd0) pend.push_back(s0);
          if (m_cr && c1v && s1.rg != 5'd0) pend.push_back(s1);
          case (mphase)
            0: if (creq) mphase = 1;
            1: if (old_sz == 0) mphase = 2;
            default: mphase = 0;
          endcase
          if (pend.size() > 0) begin
            m_out = pend.pop_front();
            m_vld = 1'b1;
          end else begin
            m_vld = 1'b0;
          end
        end
        #1;
        chk("rnd_vld", bus.rf_commit_ready, m_vld);
        if (m_vld) begin
          chk("rnd_rob", bus.rf_commit_rob_id, m_out.rob);
          chk("rnd_reg", bus.rf_commit_reg_id, m_out.rg);
          chk("rnd_val", bus.rf_commit_value, m_out.val);
        end
        chk("rnd_busy", bus.clear_busy, mphase != 0);
        chk("rnd_clr", bus.rf_clear, mphase == 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
